// File: rtl/ebrick_fpga_gpio_serdes.sv
// ebrick_fpga_gpio_serdes
// Carries the full ebrick_core GPIO bundle over a narrow FPGA pin lane.
// TX: snapshots {txgpiooe, txgpio} and sends it as a framed burst of LW-bit
// beats, LSB first, followed by a one-cycle gap.
// RX: collects a framed burst of LW-bit beats and updates core_rxgpio
// atomically when a frame of exactly the right length ends.
module ebrick_fpga_gpio_serdes #(
    parameter int NCH   = 4,
    parameter int NGPIO = 16,
    parameter int LW    = 8
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic                  enable,
    input  logic [NCH*NGPIO-1:0]  core_txgpio,
    input  logic [NCH*NGPIO-1:0]  core_txgpiooe,
    output logic [NCH*NGPIO-1:0]  core_rxgpio,
    output logic [LW-1:0]         pin_tx_data,
    output logic                  pin_tx_frame,
    input  logic [LW-1:0]         pin_rx_data,
    input  logic                  pin_rx_frame,
    output logic                  tx_frame_done,
    output logic                  rx_valid,
    output logic [7:0]            rx_err_count
);

    localparam int TXBITS  = 2 * NCH * NGPIO;
    localparam int TXBEATS = (TXBITS + LW - 1) / LW;
    localparam int RXBITS  = NCH * NGPIO;
    localparam int RXBEATS = (RXBITS + LW - 1) / LW;
    localparam int TXW     = TXBEATS * LW;
    localparam int RXW     = RXBEATS * LW;
    localparam int TXCW    = $clog2(TXBEATS + 1);
    localparam int RXCW    = $clog2(RXBEATS + 2);

    localparam logic [TXCW-1:0] TX_LAST = TXCW'(TXBEATS - 1);
    localparam logic [RXCW-1:0] RX_FULL = RXCW'(RXBEATS);
    localparam logic [RXCW-1:0] RX_OVER = RXCW'(RXBEATS + 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        GAP
    } tx_state_t;

    tx_state_t        tx_state;
    logic [TXCW-1:0]  tx_cnt;
    logic [TXW-1:0]   tx_snap;
    logic [TXW-1:0]   tx_payload;

    logic             rx_frame_q;
    logic             rx_frame_prev;
    logic [LW-1:0]    rx_data_q;
    logic [RXCW-1:0]  rx_cnt;
    logic [RXW-1:0]   rx_asm;

    // Output enables sit in the upper half; the zero-extension supplies the
    // padding bits of the final beat.
    assign tx_payload = TXW'({core_txgpiooe, core_txgpio});

    // TX framer: tx_cnt is the index of the beat currently on the pins, and
    // the pins are loaded one cycle ahead so every output is a flop.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            tx_state      <= IDLE;
            tx_cnt        <= '0;
            tx_snap       <= '0;
            pin_tx_data   <= '0;
            pin_tx_frame  <= 1'b0;
            tx_frame_done <= 1'b0;
        end else begin
            case (tx_state)
                IDLE, GAP: begin
                    if (enable) begin
                        tx_state      <= DATA;
                        tx_cnt        <= '0;
                        tx_snap       <= tx_payload;
                        pin_tx_frame  <= 1'b1;
                        pin_tx_data   <= tx_payload[LW-1:0];
                        tx_frame_done <= (TXBEATS == 1);
                    end else begin
                        tx_state      <= IDLE;
                        pin_tx_frame  <= 1'b0;
                        pin_tx_data   <= '0;
                        tx_frame_done <= 1'b0;
                    end
                end
                DATA: begin
                    if (tx_cnt == TX_LAST) begin
                        tx_state      <= GAP;
                        pin_tx_frame  <= 1'b0;
                        pin_tx_data   <= '0;
                        tx_frame_done <= 1'b0;
                    end else begin
                        tx_cnt        <= tx_cnt + TXCW'(1);
                        pin_tx_data   <= tx_snap[(int'(tx_cnt) + 1) * LW +: LW];
                        tx_frame_done <= ((tx_cnt + TXCW'(1)) == TX_LAST);
                    end
                end
                default: begin
                    tx_state      <= IDLE;
                    pin_tx_frame  <= 1'b0;
                    pin_tx_data   <= '0;
                    tx_frame_done <= 1'b0;
                end
            endcase
        end
    end

    // RX input stage: one register on the pins, plus the previous registered
    // frame level so the falling edge of a frame can be seen.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            rx_frame_q    <= 1'b0;
            rx_frame_prev <= 1'b0;
            rx_data_q     <= '0;
        end else begin
            rx_frame_q    <= pin_rx_frame;
            rx_frame_prev <= rx_frame_q;
            rx_data_q     <= pin_rx_data;
        end
    end

    // RX assembler: beats land in rx_asm while the frame is high; the counter
    // stops one past a full frame so overlong frames are still recognised as
    // malformed at the frame end.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            rx_cnt       <= '0;
            rx_asm       <= '0;
            core_rxgpio  <= '0;
            rx_valid     <= 1'b0;
            rx_err_count <= '0;
        end else begin
            rx_valid <= 1'b0;
            if (!enable) begin
                rx_cnt <= '0;
            end else if (rx_frame_q) begin
                if (rx_cnt < RX_FULL) begin
                    rx_asm[int'(rx_cnt) * LW +: LW] <= rx_data_q;
                end
                if (rx_cnt != RX_OVER) begin
                    rx_cnt <= rx_cnt + RXCW'(1);
                end
            end else if (rx_frame_prev) begin
                if (rx_cnt == RX_FULL) begin
                    core_rxgpio <= rx_asm[RXBITS-1:0];
                    rx_valid    <= 1'b1;
                end else if (rx_err_count != 8'hFF) begin
                    rx_err_count <= rx_err_count + 8'd1;
                end
                rx_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ebrick_fpga_gpio_serdes.sv
// tb_ebrick_fpga_gpio_serdes
// Checks the default-size serdes against a queue-based model on every
// cycle, with directed literal checks, and a small NCH=1/LW=5 instance
// against hand-computed beats.
module tb_ebrick_fpga_gpio_serdes;

    localparam int NCH     = 4;
    localparam int NGPIO   = 16;
    localparam int LW      = 8;
    localparam int W       = NCH * NGPIO;
    localparam int TXBEATS = 16;
    localparam int RXBEATS = 8;

    logic           clk = 1'b0;
    logic           nreset = 1'b0;
    logic           enable = 1'b0;
    logic [W-1:0]   core_txgpio = '0;
    logic [W-1:0]   core_txgpiooe = '0;
    logic [W-1:0]   core_rxgpio;
    logic [LW-1:0]  pin_tx_data;
    logic           pin_tx_frame;
    logic [LW-1:0]  pin_rx_data = '0;
    logic           pin_rx_frame = 1'b0;
    logic           tx_frame_done;
    logic           rx_valid;
    logic [7:0]     rx_err_count;

    logic           s_enable = 1'b0;
    logic [15:0]    s_txgpio = '0;
    logic [15:0]    s_txgpiooe = '0;
    logic [15:0]    s_rxgpio;
    logic [4:0]     s_tx_data;
    logic           s_tx_frame;
    logic [4:0]     s_rx_data = '0;
    logic           s_rx_frame = 1'b0;
    logic           s_done;
    logic           s_valid;
    logic [7:0]     s_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_beats [16] = '{8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01,
                                   8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    int s_exp_beats [7] = '{3, 14, 9, 31, 16, 7, 3};

    ebrick_fpga_gpio_serdes #(.NCH(NCH), .NGPIO(NGPIO), .LW(LW)) u_dut (
        .clk           (clk),
        .nreset        (nreset),
        .enable        (enable),
        .core_txgpio   (core_txgpio),
        .core_txgpiooe (core_txgpiooe),
        .core_rxgpio   (core_rxgpio),
        .pin_tx_data   (pin_tx_data),
        .pin_tx_frame  (pin_tx_frame),
        .pin_rx_data   (pin_rx_data),
        .pin_rx_frame  (pin_rx_frame),
        .tx_frame_done (tx_frame_done),
        .rx_valid      (rx_valid),
        .rx_err_count  (rx_err_count)
    );

    ebrick_fpga_gpio_serdes #(.NCH(1), .NGPIO(16), .LW(5)) u_small (
        .clk           (clk),
        .nreset        (nreset),
        .enable        (s_enable),
        .core_txgpio   (s_txgpio),
        .core_txgpiooe (s_txgpiooe),
        .core_rxgpio   (s_rxgpio),
        .pin_tx_data   (s_tx_data),
        .pin_tx_frame  (s_tx_frame),
        .pin_rx_data   (s_rx_data),
        .pin_rx_frame  (s_rx_frame),
        .tx_frame_done (s_done),
        .rx_valid      (s_valid),
        .rx_err_count  (s_err)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a whole frame of expected pin beats is queued the
    // moment a frame starts; RX keeps the beats of the current frame in a
    // queue and judges the frame only by its length when it ends.
    typedef struct packed {
        logic          frame;
        logic [LW-1:0] data;
        logic          done;
    } tx_beat_t;

    tx_beat_t       tx_q [$];
    tx_beat_t       exp_tx = '0;
    logic [LW-1:0]  rx_beats [$];
    logic [W-1:0]   exp_rx = '0;
    logic           exp_valid = 1'b0;
    logic [7:0]     exp_err = '0;
    logic           m_f = 1'b0;
    logic           m_fp = 1'b0;
    logic [LW-1:0]  m_d = '0;
    logic [2*W-1:0] m_payload;
    logic [W-1:0]   m_word;

    // Model update: inputs are sampled on the same edge the DUT sees them.
    always @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            tx_q.delete();
            rx_beats.delete();
            exp_tx    = '0;
            exp_rx    = '0;
            exp_valid = 1'b0;
            exp_err   = '0;
            m_f       = 1'b0;
            m_fp      = 1'b0;
            m_d       = '0;
        end else begin
            if (tx_q.size() == 0 && enable) begin
                m_payload = {core_txgpiooe, core_txgpio};
                for (int k = 0; k < TXBEATS; k++)
                    tx_q.push_back({1'b1, m_payload[k*LW +: LW], (k == TXBEATS - 1)});
                tx_q.push_back('0);
            end
            if (tx_q.size() > 0) exp_tx = tx_q.pop_front();
            else exp_tx = '0;

            exp_valid = 1'b0;
            if (!enable) begin
                rx_beats.delete();
            end else if (m_f) begin
                rx_beats.push_back(m_d);
            end else if (m_fp) begin
                if (rx_beats.size() == RXBEATS) begin
                    m_word = '0;
                    for (int i = 0; i < RXBEATS; i++) m_word[i*LW +: LW] = rx_beats[i];
                    exp_rx    = m_word;
                    exp_valid = 1'b1;
                end else if (exp_err != 8'd255) begin
                    exp_err++;
                end
                rx_beats.delete();
            end
            m_fp = m_f;
            m_f  = pin_rx_frame;
            m_d  = pin_rx_data;
        end
    end

    // Cycle compare of every output against the model, away from the edge.
    always @(negedge clk) begin
        check_output("tx_data", 64'(pin_tx_data), 64'(exp_tx.data));
        check_output("tx_frame", 64'(pin_tx_frame), 64'(exp_tx.frame));
        check_output("tx_done", 64'(tx_frame_done), 64'(exp_tx.done));
        check_output("rxgpio", 64'(core_rxgpio), 64'(exp_rx));
        check_output("rx_valid", 64'(rx_valid), 64'(exp_valid));
        check_output("rx_err", 64'(rx_err_count), 64'(exp_err));
    end

    // Drives one RX frame; pattern=1 sends 11,22,33,...
    task automatic send_rx_frame(input int nbeats, input bit pattern);
        for (int i = 0; i < nbeats; i++) begin
            @(negedge clk);
            pin_rx_frame = 1'b1;
            pin_rx_data  = pattern ? LW'((i + 1) * 17) : LW'($urandom);
        end
        @(negedge clk);
        pin_rx_frame = 1'b0;
        pin_rx_data  = LW'($urandom);
    endtask

    // Waits, bounded, for the last-beat pulse of the default instance.
    task automatic wait_tx_done();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = tx_frame_done;
        end
        check_output("tx_done_seen", 64'(seen), 64'd1);
    endtask

    // Directed sequences, then randomized traffic, then the small instance.
    initial begin : apply_stimulus
        logic [19:0] s_rx_word;
        int len;

        repeat (2) @(negedge clk);
        check_output("reset_tx_frame", 64'(pin_tx_frame), 64'd0);
        check_output("reset_tx_data", 64'(pin_tx_data), 64'd0);
        check_output("reset_rxgpio", 64'(core_rxgpio), 64'd0);
        check_output("reset_err", 64'(rx_err_count), 64'd0);
        nreset = 1'b1;
        @(negedge clk);

        core_txgpio   = 64'h0123_4567_89AB_CDEF;
        core_txgpiooe = '1;
        enable        = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            check_output("f1_frame", 64'(pin_tx_frame), 64'd1);
            check_output("f1_beat", 64'(pin_tx_data), 64'(exp_beats[k]));
            check_output("f1_done", 64'(tx_frame_done), 64'(k == 15));
        end
        @(negedge clk);
        check_output("f1_gap_frame", 64'(pin_tx_frame), 64'd0);
        check_output("f1_gap_data", 64'(pin_tx_data), 64'd0);

        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            check_output("f2_beat", 64'(pin_tx_data), 64'(exp_beats[k]));
            if (k == 5) core_txgpio = '0;
        end
        @(negedge clk);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            check_output("f3_beat", 64'(pin_tx_data), (k < 8) ? 64'h00 : 64'hFF);
        end

        send_rx_frame(8, 1'b1);
        @(negedge clk);
        check_output("rx_valid_early", 64'(rx_valid), 64'd0);
        @(negedge clk);
        check_output("rx_valid_pulse", 64'(rx_valid), 64'd1);
        check_output("rx_word", 64'(core_rxgpio), 64'h8877_6655_4433_2211);

        send_rx_frame(7, 1'b0);
        repeat (2) @(negedge clk);
        send_rx_frame(9, 1'b0);
        repeat (3) @(negedge clk);
        check_output("err_two", 64'(rx_err_count), 64'd2);
        check_output("rx_word_held", 64'(core_rxgpio), 64'h8877_6655_4433_2211);

        wait_tx_done();
        @(negedge clk);
        for (int k = 0; k < 4; k++) @(negedge clk);
        enable = 1'b0;
        for (int k = 4; k < 16; k++) begin
            @(negedge clk);
            check_output("dis_frame", 64'(pin_tx_frame), 64'd1);
            check_output("dis_done", 64'(tx_frame_done), 64'(k == 15));
        end
        repeat (4) begin
            @(negedge clk);
            check_output("idle_frame", 64'(pin_tx_frame), 64'd0);
            check_output("idle_data", 64'(pin_tx_data), 64'd0);
        end

        enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            pin_rx_frame = 1'b1;
            pin_rx_data  = LW'($urandom);
            if (i == 3) enable = 1'b0;
        end
        @(negedge clk);
        pin_rx_frame = 1'b0;
        repeat (4) @(negedge clk);
        check_output("dis_rx_err", 64'(rx_err_count), 64'd2);
        check_output("dis_rx_word", 64'(core_rxgpio), 64'h8877_6655_4433_2211);
        enable = 1'b1;

        core_txgpio   = 64'h0123_4567_89AB_CDEF;
        core_txgpiooe = '1;
        wait_tx_done();
        wait_tx_done();
        @(negedge clk);
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            if (k >= 6) begin
                pin_rx_frame = 1'b1;
                pin_rx_data  = LW'($urandom);
            end
        end
        #2 nreset = 1'b0;
        #1;
        check_output("arst_tx_frame", 64'(pin_tx_frame), 64'd0);
        check_output("arst_tx_data", 64'(pin_tx_data), 64'd0);
        check_output("arst_done", 64'(tx_frame_done), 64'd0);
        check_output("arst_rxgpio", 64'(core_rxgpio), 64'd0);
        check_output("arst_err", 64'(rx_err_count), 64'd0);
        @(negedge clk);
        nreset       = 1'b1;
        pin_rx_frame = 1'b0;
        @(negedge clk);
        check_output("restart_frame", 64'(pin_tx_frame), 64'd1);
        check_output("restart_beat0", 64'(pin_tx_data), 64'hEF);

        fork
            begin
                for (int c = 0; c < 1500; c++) begin
                    @(negedge clk);
                    core_txgpio   = {$urandom, $urandom};
                    core_txgpiooe = {$urandom, $urandom};
                    if ($urandom_range(0, 63) == 0) enable = ~enable;
                end
                enable = 1'b1;
            end
            begin
                for (int f = 0; f < 120; f++) begin
                    len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 11)) : 8;
                    send_rx_frame(len, 1'b0);
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                end
            end
        join
        enable = 1'b1;

        repeat (3) @(negedge clk);
        for (int f = 0; f < 256; f++) send_rx_frame(1, 1'b0);
        repeat (3) @(negedge clk);
        check_output("err_saturate", 64'(rx_err_count), 64'd255);

        @(negedge clk);
        s_txgpio   = 16'hA5C3;
        s_txgpiooe = 16'hCF0F;
        s_enable   = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            check_output("small_frame", 64'(s_tx_frame), 64'd1);
            check_output("small_beat", 64'(s_tx_data), 64'(s_exp_beats[k]));
            check_output("small_done", 64'(s_done), 64'(k == 6));
        end
        @(negedge clk);
        check_output("small_gap", 64'(s_tx_frame), 64'd0);

        s_rx_word = 20'hF9041;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            s_rx_frame = 1'b1;
            s_rx_data  = s_rx_word[i*5 +: 5];
        end
        @(negedge clk);
        s_rx_frame = 1'b0;
        @(negedge clk);
        check_output("small_valid_early", 64'(s_valid), 64'd0);
        @(negedge clk);
        check_output("small_valid", 64'(s_valid), 64'd1);
        check_output("small_rxgpio", 64'(s_rxgpio), 64'h9041);
        check_output("small_err", 64'(s_err), 64'd0);
        s_enable = 1'b0;

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Guard against a hung run.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/ebrick_fpga_gpio_serdes.md
Name: ebrick_fpga_gpio_serdes

Overview:
Time-multiplexes the full ebrick_core GPIO bundle (tx, txoe, rx on all sides) over a narrow FPGA pin lane, so every GPIO side is carried without spending three FPGA GPIOs per core GPIO. It sits between ebrick_core and the FPGA GPIO pins inside the FPGA wrapper. The TX path serializes snapshots of core txgpio/txgpiooe into framed beats. The RX path deserializes framed beats into core rxgpio, updating it atomically per frame.

Parameters:
NCH, 4, number of GPIO sides/channels carried (1..4)
NGPIO, 16, GPIOs per channel
LW, 8, lane width in bits per beat (1..32)
Derived: TXBITS=2*NCH*NGPIO; TXBEATS=ceil(TXBITS/LW); RXBITS=NCH*NGPIO; RXBEATS=ceil(RXBITS/LW)

Ports:
clk  in  1  core clock
nreset  in  1  asynchronous active-low reset
enable  in  1  1=run TX framing and RX capture
core_txgpio  in  NCH*NGPIO  core GPIO output values
core_txgpiooe  in  NCH*NGPIO  core GPIO output enables
core_rxgpio  out  NCH*NGPIO  deserialized GPIO inputs to core
pin_tx_data  out  LW  serialized TX beat
pin_tx_frame  out  1  high during every TX payload beat
pin_rx_data  in  LW  serialized RX beat
pin_rx_frame  in  1  high during every RX payload beat
tx_frame_done  out  1  one-cycle pulse on the last TX beat
rx_valid  out  1  one-cycle pulse when core_rxgpio updates
rx_err_count  out  8  saturating count of malformed RX frames

Behaviour:
- Reset (async assert, sync release): all outputs 0; TX FSM=IDLE; RX beat counter=0; core_rxgpio=0; rx_err_count=0.
- All outputs are registered.
- TX payload vector = {core_txgpiooe, core_txgpio}, i.e. txgpio bits occupy the low half. Beat k carries payload bits [k*LW +: LW], LSB first. Bits beyond TXBITS in the last beat are 0.
- TX FSM states: IDLE, DATA, GAP.
  - IDLE: pin_tx_frame=0, pin_tx_data=0. If enable=1 at an edge: snapshot the payload, go to DATA, cnt=0.
  - DATA: pin_tx_frame=1, pin_tx_data=beat cnt; cnt increments each cycle. On cnt==TXBEATS-1, tx_frame_done=1 in the same cycle and the FSM moves to GAP.
  - GAP: exactly one cycle, frame=0, data=0. If enable=1: re-snapshot and go to DATA; else go to IDLE.
- TX timing: frame period is TXBEATS+1 cycles under continuous enable. The first beat is visible the cycle after enable is first sampled high.
- Snapshot is taken only on entry to DATA; core input changes mid-frame do not affect the frame in flight.
- enable deasserted mid-frame: the current frame completes, then GAP, then IDLE.
- RX input stage: pin_rx_frame and pin_rx_data pass through one register stage before use.
- RX beat capture: while the registered frame=1 and enable=1, beat cnt is written into the assembly register at [cnt*LW +: LW]. The counter saturates at RXBEATS+1; no writes occur once cnt>=RXBEATS.
- RX frame end: a registered frame 1->0 transition is the end of frame.
  - If cnt==RXBEATS: core_rxgpio loads assembly[RXBITS-1:0] on that edge and rx_valid pulses for 1 cycle.
  - Otherwise (short or long frame): core_rxgpio holds its value and rx_err_count increments, saturating at 255.
  - In both cases cnt clears to 0.
- RX latency: core_rxgpio/rx_valid update on the 2nd clock edge after the pin-level frame falls.
- enable=0: cnt clears; a partial RX frame is discarded without an error and core_rxgpio holds. RX frames do not need to align with TX frames.
- A frame start coinciding with the previous frame's end is impossible: a frame end requires at least one low beat, and the next frame starts cleanly after it.
- Reset mid-frame: everything returns to reset values immediately; the pins go low.

Test Plan:
- Defaults (TXBEATS=16, RXBEATS=8): core_txgpio=0x0123_4567_89AB_CDEF, txgpiooe=all 1s, enable=1 -> beats 0..7 = EF,CD,AB,89,67,45,23,01; beats 8..15 = FF; frame high 16 cycles then low 1; tx_frame_done on beat 15; period 17 cycles.
- Change core_txgpio to 0 at beat 5 of a frame -> remaining beats of that frame unchanged; the next frame's beats 0..7 = 00.
- Drive an 8-beat RX frame of 11,22,..,88 -> core_rxgpio=0x8877_6655_4433_2211 and rx_valid pulses 2 edges after the pin frame falls.
- Drive a 7-beat frame, then a 9-beat frame -> core_rxgpio unchanged, rx_err_count=2, no rx_valid. Drive 256 short frames -> count stays 255.
- Deassert enable at TX beat 3 -> frame finishes all 16 beats, GAP, IDLE with pins 0. Deassert enable mid RX frame -> no update, no error.
- Assert nreset low at TX beat 10 and RX beat 4 -> all outputs 0 asynchronously; after release with enable=1, a clean frame restarts from beat 0.
- Parameter sweep NCH=1, LW=5 -> TXBEATS=7 and the last beat is zero-padded in its upper 3 bits; RXBEATS=4 and the RX padding bits are discarded.
